// File: rtl/imem_pkg.sv
// Shared types and constants for the MiniMicro instruction memory.
// Opcode constants live in bits [31:27] of an instruction word.
package imem_pkg;

  typedef enum logic {IMEM_INIT, IMEM_RUN} imem_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0;

  localparam int OPC_LSB = 27;
  localparam int OPC_W   = 5;

  localparam logic [OPC_W-1:0] OPC_NOP = 5'h00;
  localparam logic [OPC_W-1:0] OPC_ADD = 5'h01;
  localparam logic [OPC_W-1:0] OPC_SUB = 5'h02;
  localparam logic [OPC_W-1:0] OPC_LD  = 5'h08;
  localparam logic [OPC_W-1:0] OPC_ST  = 5'h09;
  localparam logic [OPC_W-1:0] OPC_BR  = 5'h13;
  localparam logic [OPC_W-1:0] OPC_JMP = 5'h14;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  // A one-word memory still needs a 1-bit address bus.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Single write port, single registered read port array. Read-first:
// a same-edge write to the read address returns the old word.
module imem_ram_1r1w
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Array is deliberately unreset; the caller's init sweep fills it.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch, loader write port and a
// post-reset sweep that fills every word with INIT_WORD.
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [DATA_W-1:0] INIT_WORD = '0,
  localparam int               ADDR_W    = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);

  imem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              wr_err_q, wr_err_d;

  logic              running;
  logic              accept;
  logic              req_in_range;
  logic              wr_in_range;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign running      = (state_q == IMEM_RUN);
  assign req_in_range = ({1'b0, req_addr} < DEPTH_X);
  assign wr_in_range  = ({1'b0, wr_addr} < DEPTH_X);

  // A held response frees the slot only when the consumer takes it.
  assign req_ready = running && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (state_q == IMEM_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        state_d     = IMEM_RUN;
        init_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !req_in_range;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    wr_err_d = wr_en && (!running || !wr_in_range);
  end

  // Sweep owns the write port until RUN; loader writes are dropped before.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cnt_q;
    ram_wdata = INIT_WORD;
    if (!running) begin
      ram_we = 1'b1;
    end else if (wr_en && wr_in_range) begin
      ram_we    = 1'b1;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
    end
  end

  assign ram_re = accept && req_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IMEM_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      wr_err_q    <= wr_err_d;
    end
  end

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .re      (ram_re),
    .rd_addr (req_addr),
    .rd_data (ram_rdata)
  );

  // Out-of-range responses never touched the array, so substitute the NOP.
  assign rsp_data  = rsp_err_q ? INIT_WORD : ram_rdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign wr_err    = wr_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: DEPTH=64 and DEPTH=48 instances, a cycle
// model compared every negedge, plus literal directed expectations.
module tb_instr_mem_fetch;
  import imem_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 6;
  localparam int DEP0 = 64;
  localparam int DEP1 = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic [AW-1:0] req_addr  [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          rsp_err   [2];
  logic          wr_en     [2];
  logic [AW-1:0] wr_addr   [2];
  logic [DW-1:0] wr_data   [2];
  logic          wr_err    [2];
  logic          init_done [2];

  instr_mem_fetch #(.DATA_W(DW), .DEPTH(DEP0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .wr_en(wr_en[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_err(wr_err[0]),
    .init_done(init_done[0]));

  instr_mem_fetch #(.DATA_W(DW), .DEPTH(DEP1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .wr_en(wr_en[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_err(wr_err[1]),
    .init_done(init_done[1]));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dep(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  // Model: memory reads back as NOP once the sweep is done; a fetch is
  // served one cycle later from the contents before any same-edge write.
  logic [DW-1:0] m_mem   [2][64];
  int            m_cyc   [2] = '{default: 0};
  bit            m_rv    [2] = '{default: 1'b0};
  bit            m_err   [2] = '{default: 1'b0};
  bit            m_wrerr [2] = '{default: 1'b0};
  logic [DW-1:0] m_data  [2] = '{default: '0};

  always @(posedge clk) begin
    bit run, acc;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_cyc[d] = 0; m_rv[d] = 0; m_err[d] = 0; m_wrerr[d] = 0; m_data[d] = '0;
        for (int k = 0; k < 64; k++) m_mem[d][k] = NOP_WORD;
      end else begin
        run = (m_cyc[d] >= dep(d));
        acc = req_valid[d] && run && (!m_rv[d] || rsp_ready[d]);
        m_wrerr[d] = wr_en[d] && (!run || int'(wr_addr[d]) >= dep(d));
        if (acc) begin
          m_rv[d] = 1'b1;
          if (int'(req_addr[d]) >= dep(d)) begin
            m_err[d] = 1'b1; m_data[d] = NOP_WORD;
          end else begin
            m_err[d] = 1'b0; m_data[d] = m_mem[d][req_addr[d]];
          end
        end else if (rsp_ready[d]) begin
          m_rv[d] = 1'b0;
        end
        if (run && wr_en[d] && int'(wr_addr[d]) < dep(d)) m_mem[d][wr_addr[d]] = wr_data[d];
        if (m_cyc[d] < 1000) m_cyc[d]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d req_ready", d), req_ready[d],
            (m_cyc[d] >= dep(d)) && (!m_rv[d] || rsp_ready[d]));
        chk($sformatf("d%0d rsp_valid", d), rsp_valid[d], m_rv[d]);
        chk($sformatf("d%0d init_done", d), init_done[d], m_cyc[d] >= dep(d));
        chk($sformatf("d%0d wr_err", d), wr_err[d], m_wrerr[d]);
        if (m_rv[d]) begin
          chk($sformatf("d%0d rsp_data", d), rsp_data[d], m_data[d]);
          chk($sformatf("d%0d rsp_err", d), rsp_err[d], m_err[d]);
        end
      end
    end
  end

  task automatic chk_rst(input int d, input string nm);
    chk({nm, " rsp_valid"}, rsp_valid[d], 0);
    chk({nm, " req_ready"}, req_ready[d], 0);
    chk({nm, " init_done"}, init_done[d], 0);
    chk({nm, " rsp_data"},  rsp_data[d],  0);
    chk({nm, " rsp_err"},   rsp_err[d],   0);
    chk({nm, " wr_err"},    wr_err[d],    0);
  endtask

  // Release reset at a negedge; after c rising edges init_done is (c==dep).
  task automatic sweep(input int d, input int dp, input bit inj);
    @(negedge clk); #2 rst[d] = 1'b0;
    for (int c = 1; c <= dp; c++) begin
      @(posedge clk); #1;
      if (inj && c == 3) begin wr_en[d] = 1'b1; wr_addr[d] = 6'd3; wr_data[d] = 32'h98004001; end
      if (inj && c == 4) wr_en[d] = 1'b0;
      @(negedge clk);
      if (inj && c == 4) chk("init write wr_err", wr_err[d], 1);
      chk("sweep init_done", init_done[d], c == dp);
      chk("sweep req_ready", req_ready[d], c == dp);
    end
  endtask

  task automatic fetch(input int d, input int a, input logic [31:0] exp, input bit experr, input string nm);
    @(posedge clk); #1; req_valid[d] = 1'b1; req_addr[d] = AW'(a);
    @(posedge clk); #1; req_valid[d] = 1'b0;
    @(negedge clk);
    chk({nm, " valid"}, rsp_valid[d], 1);
    chk({nm, " data"},  rsp_data[d],  exp);
    chk({nm, " err"},   rsp_err[d],   experr);
  endtask

  task automatic write(input int d, input int a, input logic [31:0] v, input bit experr, input string nm);
    @(posedge clk); #1; wr_en[d] = 1'b1; wr_addr[d] = AW'(a); wr_data[d] = v;
    @(posedge clk); #1; wr_en[d] = 1'b0;
    @(negedge clk);
    chk({nm, " wr_err"}, wr_err[d], experr);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b1;
      wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0;
    end
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk_rst(0, "reset d0");
    chk_rst(1, "reset d1");

    // DEPTH=64: sweep, then every word fetches as NOP.
    sweep(0, DEP0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < DEP0; i++) begin
      req_valid[0] = 1'b1; req_addr[0] = AW'(i);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("fetch63 data", rsp_data[0], 32'h0);
    chk("fetch63 err", rsp_err[0], 0);

    // Load two words, fetch them back to back.
    write(0, 1, 32'h98004001, 1'b0, "load1");
    write(0, 2, 32'h98008002, 1'b0, "load2");
    @(posedge clk); #1; req_valid[0] = 1'b1; req_addr[0] = 6'd1;
    @(posedge clk); #1; req_addr[0] = 6'd2;
    @(negedge clk);
    chk("b2b first", rsp_data[0], 32'h98004001);
    chk("b2b opcode", opcode_of(rsp_data[0]), OPC_BR);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b second valid", rsp_valid[0], 1);
    chk("b2b second", rsp_data[0], 32'h98008002);

    // Backpressure: response to addr1 held for three cycles.
    @(posedge clk); #1; rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_addr[0] = 6'd1;
    @(posedge clk); #1; req_addr[0] = 6'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp hold data", rsp_data[0], 32'h98004001);
      chk("bp req_ready", req_ready[0], 0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp release ready", req_ready[0], 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp next data", rsp_data[0], 32'h98008002);

    // Same-edge write and fetch of addr5: old word first.
    @(posedge clk); #1;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 32'h40004805;
    req_valid[0] = 1'b1; req_addr[0] = 6'd5;
    @(posedge clk); #1; wr_en[0] = 1'b0;
    @(negedge clk);
    chk("collide old", rsp_data[0], 32'h0);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("collide new", rsp_data[0], 32'h40004805);
    chk("collide opcode", opcode_of(rsp_data[0]), OPC_LD);

    // Reset with a response pending, then a full re-sweep.
    @(posedge clk); #1; rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_addr[0] = 6'd1;
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre-reset valid", rsp_valid[0], 1);
    #2 rst[0] = 1'b1;
    #1 chk_rst(0, "midrun rst");
    rsp_ready[0] = 1'b1;
    sweep(0, DEP0, 1'b0);
    fetch(0, 1, 32'h0, 1'b0, "after resweep addr1");

    // DEPTH=48: abort at sweep count 20, re-sweep with a rejected write.
    @(negedge clk); #2 rst[1] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 rst[1] = 1'b1;
    #1 chk_rst(1, "midsweep rst");
    sweep(1, DEP1, 1'b1);
    fetch(1, 3, 32'h0, 1'b0, "init write dropped");
    fetch(1, 50, 32'h0, 1'b1, "oor fetch50");
    fetch(1, 47, 32'h0, 1'b0, "last word");
    write(1, 60, 32'h12345678, 1'b1, "oor write60");
    write(1, 10, 32'h0800000a, 1'b0, "write10");
    fetch(1, 10, 32'h0800000a, 1'b0, "fetch10");

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
